// File: rtl/scan_index_counter_if.sv
// Control/status bundle between a block-transform controller and the
// raster index counter: the controller issues restart/go, the counter
// returns the current (u,v) element and the terminal-element flag.
interface scan_index_counter_if #(
    parameter int COUNT_WIDTH = 3
);
    logic                   restart;
    logic                   go;
    logic [COUNT_WIDTH-1:0] u;
    logic [COUNT_WIDTH-1:0] v;
    logic                   done;

    modport master (
        output restart,
        output go,
        input  u,
        input  v,
        input  done
    );

    modport slave (
        input  restart,
        input  go,
        output u,
        output v,
        output done
    );
endinterface

// File: rtl/scan_index_counter.sv
// Two-dimensional raster index generator. v is the fast index, u the slow
// one; done flags the last element (U_MAX,V_MAX). State lives in generic
// enable flops with a per-instance reset value.

// Generic enable flop: reset loads rst_val, otherwise en loads D.
module scan_index_en_flop #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,   // active-high synchronous reset
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state select: load D when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = D;
        end
    end

    // State register; reset takes precedence over the enable.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;
endmodule

module scan_index_counter #(
    parameter int COUNT_WIDTH = 3,
    parameter int U_MAX       = 7,
    parameter int V_MAX       = 7
) (
    input  logic                clk,
    input  logic                rst_n,   // active-high synchronous reset
    scan_index_counter_if.slave sif
);
    localparam logic [COUNT_WIDTH-1:0] U_LAST = U_MAX[COUNT_WIDTH-1:0];
    localparam logic [COUNT_WIDTH-1:0] V_LAST = V_MAX[COUNT_WIDTH-1:0];
    localparam logic [COUNT_WIDTH-1:0] ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] ZERO   = '0;

    logic [COUNT_WIDTH-1:0] u_q;
    logic [COUNT_WIDTH-1:0] v_q;
    logic [COUNT_WIDTH-1:0] u_d;
    logic [COUNT_WIDTH-1:0] v_d;
    logic                   idx_en;

    // Next element in raster order; restart outranks go, and the flops
    // only load when one of them is active so the indices otherwise hold.
    always_comb begin
        u_d    = u_q;
        v_d    = v_q;
        idx_en = sif.restart | sif.go;
        if (sif.restart) begin
            u_d = ZERO;
            v_d = ZERO;
        end else if (sif.go) begin
            if (v_q != V_LAST) begin
                v_d = v_q + ONE;
            end else begin
                v_d = ZERO;
                u_d = (u_q != U_LAST) ? (u_q + ONE) : ZERO;
            end
        end
    end

    scan_index_en_flop #(.WIDTH(COUNT_WIDTH)) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (idx_en),
        .rst_val (ZERO),
        .D       (u_d),
        .Q       (u_q)
    );

    scan_index_en_flop #(.WIDTH(COUNT_WIDTH)) v_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (idx_en),
        .rst_val (ZERO),
        .D       (v_d),
        .Q       (v_q)
    );

    // done is decoded from the registered indices so the consumer sees it
    // in the same cycle as the terminal element, independent of go.
    assign sif.u    = u_q;
    assign sif.v    = v_q;
    assign sif.done = (u_q == U_LAST) && (v_q == V_LAST);
endmodule

// File: tb/tb_scan_index_counter.sv
// Bench for scan_index_counter: directed steps plus a randomized phase,
// checked against a linear-element-index reference model.
module tb_scan_index_counter;
    localparam int CW    = 3;
    localparam int U_MAX = 7;
    localparam int V_MAX = 7;
    localparam int NCOL  = V_MAX + 1;
    localparam int NELEM = (U_MAX + 1) * (V_MAX + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scan_index_counter_if #(.COUNT_WIDTH(CW)) sif ();

    scan_index_counter #(.COUNT_WIDTH(CW), .U_MAX(U_MAX), .V_MAX(V_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    logic       ef_rst;
    logic       ef_en;
    logic [3:0] ef_rv;
    logic [3:0] ef_d;
    logic [3:0] ef_q;

    scan_index_en_flop #(.WIDTH(4)) ef (
        .clk     (clk),
        .rst_n   (ef_rst),
        .en      (ef_en),
        .rst_val (ef_rv),
        .D       (ef_d),
        .Q       (ef_q)
    );

    int tests = 0;
    int fails = 0;
    int idx   = 0;   // model: linear position in the sweep

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idx(input string tag);
        check({tag, ".u"},    {29'd0, sif.u},    idx / NCOL);
        check({tag, ".v"},    {29'd0, sif.v},    idx % NCOL);
        check({tag, ".done"}, {31'd0, sif.done}, (idx == NELEM - 1) ? 1 : 0);
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic tick(input string tag, input logic r, input logic rs, input logic g);
        rst_n       = r;
        sif.restart = rs;
        sif.go      = g;
        @(posedge clk);
        if (r || rs)  idx = 0;
        else if (g)   idx = (idx + 1) % NELEM;
        #1;
        check_idx(tag);
    endtask

    task automatic go_to(input string tag, input int target);
        for (int i = 0; i < NELEM && idx != target; i++) tick(tag, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b1; sif.restart = 1'b0; sif.go = 1'b1;
        ef_rst = 1'b1; ef_en = 1'b0; ef_rv = 4'd3; ef_d = 4'd0;

        // Reset with go high: two cycles at (0,0)
        tick("reset0", 1'b1, 1'b0, 1'b1);
        tick("reset1", 1'b1, 1'b0, 1'b1);
        tick("first_go", 1'b0, 1'b0, 1'b1);

        // Full sweep from (0,0) including wrap
        tick("restart_a", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < NELEM; i++) tick("sweep", 1'b0, 1'b0, 1'b1);

        // Hold at (3,5) then resume
        tick("restart_b", 1'b0, 1'b1, 1'b0);
        go_to("to35", 3 * NCOL + 5);
        for (int i = 0; i < 5; i++) tick("hold35", 1'b0, 1'b0, 1'b0);
        tick("resume36", 1'b0, 1'b0, 1'b1);

        // restart beats go at (5,2)
        go_to("to52", 5 * NCOL + 2);
        tick("restart_go", 1'b0, 1'b1, 1'b1);

        // Park at terminal element, done stays high, then restart
        go_to("to77", NELEM - 1);
        for (int i = 0; i < 10; i++) tick("park77", 1'b0, 1'b0, 1'b0);
        tick("restart77", 1'b0, 1'b1, 1'b0);

        // Reset mid-sweep beats go
        go_to("to44", 4 * NCOL + 4);
        tick("rst44", 1'b1, 1'b0, 1'b1);

        // Randomized control
        for (int i = 0; i < 400; i++) begin
            tick("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7));
        end
        sif.go = 1'b0; rst_n = 1'b0;

        // Enable flop on its own
        @(posedge clk); #1;
        check("ef_reset3", {28'd0, ef_q}, 3);
        ef_rst = 1'b0; ef_en = 1'b0; ef_d = 4'd5;
        @(posedge clk); #1;
        check("ef_hold", {28'd0, ef_q}, 3);
        ef_en = 1'b1;
        @(posedge clk); #1;
        check("ef_load5", {28'd0, ef_q}, 5);
        ef_rst = 1'b1; ef_rv = 4'd2; ef_d = 4'd9;
        @(posedge clk); #1;
        check("ef_reset2", {28'd0, ef_q}, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
